// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer sequencing controller.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ALARM = 2'd3
  } state_t;

  // Cycles spent in LOAD so the timer datapath reloads from the new preset.
  localparam int LOAD_CYCLES = 2;

  localparam logic [15:0] BCD_ZERO = 16'h0000;

endpackage

// File: rtl/timer_ctrl_btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; holding the input
// high yields exactly one pulse.
module btn_edge (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/timer_ctrl.sv
// Run/stop sequencer for the minute-preset countdown timer: button edges,
// preset freeze, expiry detection and a time-limited blinking alarm.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int ALARM_SEC = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_go,
  input  logic        btn_stop,
  input  logic [3:0]  sw,
  input  logic [15:0] timer,
  output logic        run,
  output logic [3:0]  preset,
  output logic        alarm,
  output logic        led_blink,
  output logic        busy,
  output logic [1:0]  state
);

  localparam int ALARM_LIMIT = ALARM_SEC * CLK_HZ;
  localparam int AW          = $clog2(ALARM_LIMIT + 1);
  localparam int BLINK_DIV   = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int BW          = $clog2(BLINK_DIV + 1);

  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_LIMIT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [1:0]    LOAD_LAST  = 2'(LOAD_CYCLES - 1);

  state_t          cur;
  state_t          nxt;
  logic            go;
  logic            stop;
  logic [1:0]      load_cnt;
  logic            run_seen;
  logic [AW-1:0]   alarm_cnt;
  logic [BW-1:0]   blink_cnt;

  btn_edge u_go (
    .clk   (clk),
    .rstn  (rstn),
    .in    (btn_go),
    .pulse (go)
  );

  btn_edge u_stop (
    .clk   (clk),
    .rstn  (rstn),
    .in    (btn_stop),
    .pulse (stop)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Stop has priority over expiry so a cancel never leaves a stray alarm.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: begin
        if (go && sw != 4'd0) nxt = LOAD;
      end
      LOAD: begin
        if (stop)                       nxt = IDLE;
        else if (load_cnt == LOAD_LAST) nxt = RUN;
      end
      RUN: begin
        if (stop)                                nxt = IDLE;
        else if (run_seen && timer == BCD_ZERO)  nxt = ALARM;
      end
      ALARM: begin
        if (go || stop || alarm_cnt == ALARM_LAST) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // The first RUN cycle still sees the pre-start timer value, so expiry is
  // only trusted once a full RUN cycle has elapsed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_cnt  <= 2'd0;
      run_seen  <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      load_cnt  <= (cur == LOAD && nxt == LOAD) ? load_cnt + 2'd1 : 2'd0;
      run_seen  <= (cur == RUN && nxt == RUN);
      alarm_cnt <= (cur == ALARM && nxt == ALARM) ? alarm_cnt + AW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blink_cnt <= '0;
      led_blink <= 1'b0;
    end else if (cur == ALARM && nxt == ALARM) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        led_blink <= ~led_blink;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt <= '0;
      led_blink <= (nxt == ALARM);
    end
  end

  // Outputs follow the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run    <= 1'b0;
      alarm  <= 1'b0;
      busy   <= 1'b0;
      preset <= 4'd0;
    end else begin
      run   <= (nxt == RUN) || (nxt == ALARM);
      alarm <= (nxt == ALARM);
      busy  <= (nxt != IDLE);
      if (cur == IDLE && nxt == LOAD) preset <= sw;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized and directed bench for timer_ctrl against a behavioural model
// of the sequencer and of the countdown datapath it drives.
module tb_timer_ctrl;

  localparam int CLK_HZ    = 8;
  localparam int ALARM_SEC = 2;
  localparam int LOAD_LEN  = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        btn_go;
  logic        btn_stop;
  logic [3:0]  sw;
  logic [15:0] timer;
  logic        run;
  logic [3:0]  preset;
  logic        alarm;
  logic        led_blink;
  logic        busy;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  // Model: state as 0..3, time spent in current state, latched preset,
  // sampled button level history and the countdown datapath in seconds.
  int m_state, m_time, m_preset;
  bit hist_go [3];
  bit hist_stop [3];
  int tm_secs, tm_ticks;

  int loadEntries;
  bit alarmSeen;
  logic [1:0] prevDutState;

  timer_ctrl #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_go    (btn_go),
    .btn_stop  (btn_stop),
    .sw        (sw),
    .timer     (timer),
    .run       (run),
    .preset    (preset),
    .alarm     (alarm),
    .led_blink (led_blink),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_state  = 0;
    m_time   = 0;
    m_preset = 0;
    tm_secs  = 0;
    tm_ticks = 0;
    for (int i = 0; i < 3; i++) begin
      hist_go[i]   = 1'b0;
      hist_stop[i] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    bit go_p, stop_p, old_run;
    int old_preset, nxt;
    go_p       = hist_go[1] && !hist_go[2];
    stop_p     = hist_stop[1] && !hist_stop[2];
    old_run    = (m_state == 2) || (m_state == 3);
    old_preset = m_preset;
    nxt        = m_state;
    case (m_state)
      0: if (go_p && sw != 4'd0) begin nxt = 1; m_preset = int'(sw); end
      1: if (stop_p) nxt = 0; else if (m_time == LOAD_LEN - 1) nxt = 2;
      2: if (stop_p) nxt = 0; else if (m_time >= 1 && tm_secs == 0) nxt = 3;
      default: if (go_p || stop_p || m_time == ALARM_SEC * CLK_HZ - 1) nxt = 0;
    endcase
    m_time  = (nxt != m_state) ? 0 : m_time + 1;
    m_state = nxt;
    if (!old_run) begin
      tm_secs  = old_preset * 60;
      tm_ticks = 0;
    end else if (tm_ticks == CLK_HZ - 1) begin
      tm_ticks = 0;
      if (tm_secs > 0) tm_secs--;
    end else begin
      tm_ticks++;
    end
    hist_go[2]   = hist_go[1];
    hist_go[1]   = hist_go[0];
    hist_go[0]   = btn_go;
    hist_stop[2] = hist_stop[1];
    hist_stop[1] = hist_stop[0];
    hist_stop[0] = btn_stop;
  endtask

  task automatic checkAll();
    bit exp_blink;
    exp_blink = (m_state == 3) && (((m_time / (CLK_HZ / 4)) % 2) == 0);
    checkOutput("state", 32'(state), 32'(m_state));
    checkOutput("run", 32'(run), 32'((m_state == 2) || (m_state == 3)));
    checkOutput("preset", 32'(preset), 32'(m_preset));
    checkOutput("alarm", 32'(alarm), 32'(m_state == 3));
    checkOutput("led_blink", 32'(led_blink), 32'(exp_blink));
    checkOutput("busy", 32'(busy), 32'(m_state != 0));
    if (state == 2'd1 && prevDutState == 2'd0) loadEntries++;
    if (alarm) alarmSeen = 1'b1;
    prevDutState = state;
  endtask

  // One call drives the given levels for n cycles, advancing and checking the model.
  task automatic applyStimulus(input bit g, input bit s, input logic [3:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      btn_go   = g;
      btn_stop = s;
      sw       = w;
      @(posedge clk);
      modelEdge();
      #1;
      timer = toBcd(tm_secs);
      checkAll();
      @(negedge clk);
    end
  endtask

  task automatic waitForModelState(input int target, input logic [3:0] w, input string tag);
    int budget;
    budget = 0;
    while (m_state != target && budget < 3000) begin
      applyStimulus(1'b0, 1'b0, w, 1);
      budget++;
    end
    if (m_state != target) checkOutput(tag, 32'(m_state), 32'(target));
  endtask

  task automatic asyncReset();
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_run", 32'(run), 32'd0);
    checkOutput("rst_preset", 32'(preset), 32'd0);
    checkOutput("rst_alarm", 32'(alarm), 32'd0);
    checkOutput("rst_blink", 32'(led_blink), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_state", 32'(state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    modelReset();
    timer = toBcd(tm_secs);
    prevDutState = 2'd0;
  endtask

  initial begin
    int budget;
    rstn = 1'b0;
    btn_go = 1'b0;
    btn_stop = 1'b0;
    sw = 4'd0;
    timer = 16'h0000;
    prevDutState = 2'd0;
    loadEntries = 0;
    alarmSeen = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkAll();
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] zero preset");
    applyStimulus(1'b1, 1'b0, 4'd0, 3);
    applyStimulus(1'b0, 1'b0, 4'd0, 6);
    checkOutput("zero_state", 32'(state), 32'd0);
    checkOutput("zero_preset", 32'(preset), 32'd0);

    $display("[TB] normal expiry");
    alarmSeen = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd1, 3);
    checkOutput("go_latency", 32'(state), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'd1, 2);
    checkOutput("start_latency", 32'(run), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'd1, 520);
    checkOutput("expiry_alarm_seen", 32'(alarmSeen), 32'd1);
    checkOutput("expiry_back_idle", 32'(state), 32'd0);

    $display("[TB] cancel mid-run");
    applyStimulus(1'b1, 1'b0, 4'd3, 3);
    applyStimulus(1'b0, 1'b0, 4'd3, 44);
    applyStimulus(1'b0, 1'b0, 4'd7, 5);
    applyStimulus(1'b0, 1'b1, 4'd7, 3);
    checkOutput("cancel_state", 32'(state), 32'd0);
    checkOutput("cancel_preset", 32'(preset), 32'd3);
    applyStimulus(1'b0, 1'b0, 4'd7, 4);

    $display("[TB] acknowledge with go");
    applyStimulus(1'b1, 1'b0, 4'd1, 3);
    applyStimulus(1'b0, 1'b0, 4'd1, 2);
    waitForModelState(3, 4'd1, "ack_reach_alarm");
    applyStimulus(1'b0, 1'b0, 4'd1, 3);
    applyStimulus(1'b1, 1'b0, 4'd1, 3);
    checkOutput("ack_state", 32'(state), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd1, 10);
    checkOutput("ack_no_restart", 32'(run), 32'd0);

    $display("[TB] stop coinciding with zero");
    applyStimulus(1'b1, 1'b0, 4'd1, 3);
    applyStimulus(1'b0, 1'b0, 4'd1, 3);
    budget = 0;
    while (!(m_state == 2 && tm_secs == 1 && tm_ticks == CLK_HZ - 2) && budget < 1000) begin
      applyStimulus(1'b0, 1'b0, 4'd1, 1);
      budget++;
    end
    if (budget >= 1000) checkOutput("coincide_reach", 32'(budget), 32'd0);
    alarmSeen = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'd1, 6);
    checkOutput("coincide_no_alarm", 32'(alarmSeen), 32'd0);
    checkOutput("coincide_state", 32'(state), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd1, 4);

    $display("[TB] async reset during run");
    applyStimulus(1'b1, 1'b0, 4'd2, 3);
    applyStimulus(1'b0, 1'b0, 4'd2, 20);
    applyStimulus(1'b1, 1'b0, 4'd2, 5);
    btn_go = 1'b1;
    asyncReset();
    loadEntries = 0;
    applyStimulus(1'b1, 1'b0, 4'd2, 3);
    checkOutput("post_reset_load", 32'(state), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'd2, 10);
    checkOutput("post_reset_loads", 32'(loadEntries), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'd2, 4);
    applyStimulus(1'b0, 1'b0, 4'd2, 5);

    $display("[TB] held button");
    loadEntries = 0;
    applyStimulus(1'b1, 1'b0, 4'd2, 100);
    checkOutput("held_loads_100", 32'(loadEntries), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'd2, 1000);
    checkOutput("held_loads_after_expiry", 32'(loadEntries), 32'd1);
    checkOutput("held_idle", 32'(state), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd2, 5);

    $display("[TB] random stimulus");
    for (int it = 0; it < 60; it++) begin
      logic [3:0] w;
      w = 4'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: applyStimulus(1'b1, 1'b0, w, $urandom_range(1, 6));
        1: applyStimulus(1'b0, 1'b1, w, $urandom_range(1, 6));
        2: applyStimulus(1'b0, 1'b0, w, $urandom_range(1, 30));
        3: applyStimulus(1'b1, 1'b1, w, $urandom_range(1, 4));
        default: applyStimulus(1'b0, 1'b0, w, $urandom_range(100, 600));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the minute-preset countdown timer on the board. It turns two push-buttons into a clean run/stop sequence and freezes the switch preset for the whole run. It detects expiry from the timer's BCD mm:ss output and drives a time-limited, blinking alarm. It sits between the debounced button inputs, the `sw[3:0]` switches and the countdown datapath, whose `start` and `sw` inputs it owns.

## Interface
- `CLK_HZ`, 100_000_000, clock frequency; one second = `CLK_HZ` cycles.
- `ALARM_SEC`, 10, alarm auto-clear time in seconds.
- `clk`  in  1  system clock; rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `btn_go`  in  1  debounced, asynchronous start/acknowledge button level.
- `btn_stop`  in  1  debounced, asynchronous cancel/acknowledge button level.
- `sw`  in  4  preset minutes, 0–15.
- `timer`  in  16  timer value as BCD: [15:12] tens of minutes, [11:8] minutes, [7:4] tens of seconds, [3:0] seconds.
- `run`  out  1  to the timer's `start`: 1 = count down, 0 = hold reloaded at `preset`×60.
- `preset`  out  4  latched minutes, to the timer's `sw` input.
- `alarm`  out  1  high for the whole ALARM state.
- `led_blink`  out  1  2 Hz square wave during ALARM, 0 otherwise.
- `busy`  out  1  state ≠ IDLE.
- `state`  out  2  current state encoding, for debug LEDs.

## Operation
- States: IDLE=0, LOAD=1, RUN=2, ALARM=3.
- All outputs are registered. Reset values: `run`=0, `preset`=0, `alarm`=0, `led_blink`=0, `busy`=0, `state`=IDLE. All internal counters reset to 0.
- **Button handling.** Each button passes through a 2-FF synchronizer and a previous-value register. `go`/`stop` are one-cycle rising-edge pulses. Holding a button produces a single pulse.
- **IDLE** (`run`=0).
  - `go` with `sw`≠0: latch `preset`←`sw`, go to LOAD.
  - `go` with `sw`=0: ignored, remain IDLE.
  - `stop`: no effect.
- **LOAD** (`run`=0).
  - Stays for exactly 2 cycles so the timer reloads from the new `preset`, then goes to RUN.
  - `stop` during LOAD → IDLE.
- **RUN** (`run`=1).
  - `stop` → IDLE.
  - `timer`==16'h0000 → ALARM.
  - `stop` and zero in the same cycle: `stop` wins, go to IDLE with no alarm.
  - `go` is ignored.
  - Zero detection is qualified from the 2nd RUN cycle onward.
- **ALARM** (`run`=1, so the display holds 00:00; `alarm`=1).
  - `led_blink` toggles every `CLK_HZ/4` cycles and starts at 1 on entry.
  - `go` or `stop` acknowledges → IDLE. `go` does not restart the timer.
  - After `ALARM_SEC`×`CLK_HZ` cycles in ALARM → IDLE.
- **Preset freeze.** `preset` changes only on the IDLE→LOAD transition. `sw` changes at any other time are ignored, and `preset` keeps its value in IDLE.
- **Widths.** Counters are sized with `$clog2` from the parameters. The alarm counter width must hold `ALARM_SEC*CLK_HZ` (30 bits at the defaults).

## Timing
- **Button latency.** A button rising between edges 0 and 1 changes `state` at edge 3: synchronizer stage 1 at edge 1, stage 2 at edge 2, pulse active in cycle 2–3.
- **Start latency.** From the state change into LOAD, `run` rises exactly 2 cycles later.
- **Expiry latency.** The cycle in which `timer` reads 0 in RUN is followed by ALARM at the next edge.
- **Stop latency.** `run` falls on the same edge that the state leaves RUN or ALARM.
- **Reset mid-operation.** Asserting `rstn`=0 forces all reset values immediately, whatever the state. On deassertion, a button level already high must not produce a pulse: the synchronizer and previous-value registers reset to 0, so a held button yields one pulse after 2 edges. This is the required behaviour.

## Structure
- **Package `timer_pkg`:** state enum (IDLE/LOAD/RUN/ALARM and their encodings), `LOAD_CYCLES`=2, and BCD-zero constant 16'h0000.
- **Sub-module `btn_edge`:** 2-FF synchronizer plus rising-edge pulse, ports `clk`, `rstn`, `in`, `pulse`. Instantiated twice.
- **Top:** the FSM, preset latch, blink divider and alarm timeout counter stay in `timer_ctrl`.

## Test plan
All scenarios use `CLK_HZ`=8 and `ALARM_SEC`=2, with a behavioural timer model that reloads `preset`×60 when `run`=0 and decrements once per second when `run`=1.
- **Normal expiry.** `sw`=1, pulse `btn_go` → `state`=LOAD at edge 3, `run`=1 two cycles later, the timer counts down 60 s, then `alarm`=1 with `led_blink` toggling every 2 cycles, and IDLE after 16 cycles.
- **Zero preset.** `sw`=0, pulse `btn_go` → stays IDLE; `run`, `busy` and `preset` remain 0.
- **Cancel mid-run.** `sw`=3, run for 5 s, change `sw`=7, then pulse `btn_stop` → IDLE and `run`=0. `preset` stays 3 throughout; the timer reloads to BCD 0300.
- **Acknowledge and simultaneous events.** In ALARM, pulse `btn_go` → IDLE in 3 cycles with no restart. In RUN, assert `btn_stop` so its pulse coincides with `timer`=0 → IDLE, and `alarm` never rises.
- **Async reset.** Assert `rstn`=0 during RUN with `btn_go` held high → all outputs 0 immediately. After release, exactly one `go` pulse occurs and the controller enters LOAD.
- **Held button.** Hold `btn_go` high for 100 cycles in IDLE with `sw`=2 → exactly one IDLE→LOAD transition; no re-trigger after expiry while the button is still held.
